// File: rtl/seven_seg_scan_decoder.sv
// Loopback monitor for a multiplexed 4-digit seven-segment display.
// It rebuilds the BCD value being shown. Define SEG_ALT_GLYPH_EN to also accept the tailed 6 and 9 glyphs.
module seven_seg_scan_decoder #(
  parameter int STABLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 50000000,
  parameter int CNT_W          = 26
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        an0,
  input  logic        an1,
  input  logic        an2,
  input  logic        an3,
  input  logic        ca,
  input  logic        cb,
  input  logic        cc,
  input  logic        cd,
  input  logic        ce,
  input  logic        cf,
  input  logic        cg,
  output logic [15:0] bcd_out,
  output logic        frame_valid,
  output logic [3:0]  blank_mask,
  output logic [3:0]  bad_mask,
  output logic        seq_err,
  output logic        no_signal
);

  localparam int SW = $clog2(STABLE_CYCLES + 1);
  localparam logic [SW-1:0]    STAB_LAST = SW'(STABLE_CYCLES - 1);
  localparam logic [SW-1:0]    STAB_SAT  = SW'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] TMO_MAX   = CNT_W'(TIMEOUT_CYCLES);

  typedef enum logic {SYNC, COLLECT} state_t;

  logic [10:0]      raw_vec;
  logic [10:0]      sync1_reg, sync2_reg, prev_reg;
  logic [SW-1:0]    stab_cnt_reg;
  logic             accept;
  logic [3:0]       an_vec;
  logic [6:0]       seg_vec;
  logic             an_ok;
  logic [1:0]       idx;
  logic [3:0]       glyph_nib;
  logic             glyph_blank, glyph_bad;

  state_t           state_reg, state_next;
  logic [1:0]       exp_reg, exp_next;
  logic             store, clear, commit, seq_err_next;
  logic [15:0]      bcd_asm_reg, bcd_asm_next;
  logic [3:0]       blank_asm_reg, blank_asm_next;
  logic [3:0]       bad_asm_reg, bad_asm_next;
  logic [CNT_W-1:0] tmo_reg;

  assign raw_vec = {an3, an2, an1, an0, cg, cf, ce, cd, cc, cb, ca};

  // The stability counter saturates one past the accept point, so a held vector is accepted only once.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_reg    <= '1;
      sync2_reg    <= '1;
      prev_reg     <= '1;
      stab_cnt_reg <= '0;
    end else begin
      sync1_reg <= raw_vec;
      sync2_reg <= sync1_reg;
      prev_reg  <= sync2_reg;
      if (sync2_reg != prev_reg)
        stab_cnt_reg <= '0;
      else if (stab_cnt_reg != STAB_SAT)
        stab_cnt_reg <= stab_cnt_reg + 1'b1;
    end
  end

  assign accept  = (stab_cnt_reg == STAB_LAST);
  assign an_vec  = prev_reg[10:7];
  assign seg_vec = prev_reg[6:0];

  always_comb begin
    an_ok = 1'b1;
    idx   = 2'd0;
    case (an_vec)
      4'b1110: idx = 2'd0;
      4'b1101: idx = 2'd1;
      4'b1011: idx = 2'd2;
      4'b0111: idx = 2'd3;
      default: an_ok = 1'b0;
    endcase
  end

  // Segment bits are ordered {g,f,e,d,c,b,a}, and a lit segment reads as 0.
  always_comb begin
    glyph_nib   = 4'hE;
    glyph_blank = 1'b0;
    glyph_bad   = 1'b0;
    case (seg_vec)
      7'b1000000: glyph_nib = 4'h0;
      7'b1111001: glyph_nib = 4'h1;
      7'b0100100: glyph_nib = 4'h2;
      7'b0110000: glyph_nib = 4'h3;
      7'b0011001: glyph_nib = 4'h4;
      7'b0010010: glyph_nib = 4'h5;
      7'b0000011: glyph_nib = 4'h6;
      7'b1111000: glyph_nib = 4'h7;
      7'b0000000: glyph_nib = 4'h8;
      7'b0011000: glyph_nib = 4'h9;
`ifdef SEG_ALT_GLYPH_EN
      7'b0000010: glyph_nib = 4'h6;
      7'b0010000: glyph_nib = 4'h9;
`endif
      7'b1111111: begin
        glyph_nib   = 4'hF;
        glyph_blank = 1'b1;
      end
      default: begin
        glyph_nib = 4'hE;
        glyph_bad = 1'b1;
      end
    endcase
  end

  always_comb begin
    state_next   = state_reg;
    exp_next     = exp_reg;
    store        = 1'b0;
    clear        = 1'b0;
    commit       = 1'b0;
    seq_err_next = 1'b0;
    if (accept && an_ok) begin
      case (state_reg)
        SYNC: begin
          if (idx == 2'd0) begin
            store      = 1'b1;
            clear      = 1'b1;
            exp_next   = 2'd1;
            state_next = COLLECT;
          end
        end
        default: begin
          if (idx == exp_reg) begin
            store = 1'b1;
            if (exp_reg == 2'd3) begin
              commit   = 1'b1;
              exp_next = 2'd0;
            end else begin
              exp_next = exp_reg + 2'd1;
            end
          end else begin
            seq_err_next = 1'b1;
            clear        = 1'b1;
            if (idx == 2'd0) begin
              store    = 1'b1;
              exp_next = 2'd1;
            end else begin
              exp_next   = 2'd0;
              state_next = SYNC;
            end
          end
        end
      endcase
    end
  end

  // A store overrides the clear, so a restart at digit 0 keeps the new digit.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_digit
      logic hit;
      assign hit = store && (idx == 2'(gi));
      assign bcd_asm_next[4*gi +: 4] = hit ? glyph_nib
                                     : (clear ? 4'h0 : bcd_asm_reg[4*gi +: 4]);
      assign blank_asm_next[gi] = hit ? glyph_blank : (clear ? 1'b0 : blank_asm_reg[gi]);
      assign bad_asm_next[gi]   = hit ? glyph_bad   : (clear ? 1'b0 : bad_asm_reg[gi]);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= SYNC;
      exp_reg       <= 2'd0;
      bcd_asm_reg   <= '0;
      blank_asm_reg <= '0;
      bad_asm_reg   <= '0;
      bcd_out       <= '0;
      blank_mask    <= '0;
      bad_mask      <= '0;
      frame_valid   <= 1'b0;
      seq_err       <= 1'b0;
      tmo_reg       <= '0;
    end else begin
      state_reg     <= state_next;
      exp_reg       <= exp_next;
      bcd_asm_reg   <= bcd_asm_next;
      blank_asm_reg <= blank_asm_next;
      bad_asm_reg   <= bad_asm_next;
      frame_valid   <= commit;
      seq_err       <= seq_err_next;
      if (commit) begin
        bcd_out    <= bcd_asm_next;
        blank_mask <= blank_asm_next;
        bad_mask   <= bad_asm_next;
      end
      if (commit)
        tmo_reg <= '0;
      else if (tmo_reg != TMO_MAX)
        tmo_reg <= tmo_reg + 1'b1;
    end
  end

  assign no_signal = (tmo_reg == TMO_MAX);

endmodule
